// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32I-subset core. A Moore FSM that walks
// each instruction through fetch/decode/execute/memory/writeback and drives
// every datapath select, write enable and memory handshake.
module multicycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic        EQ,
    input  logic        MemReady,
    output logic        MemReq,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUctrl,
    output logic        InstrDone,
    output logic        Illegal
);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StTrap
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    state_e      state_q, state_d;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [1:0]  aluop;

    // Raw enables before reset gating.
    logic        mem_req, mem_write, ir_write, pc_write, reg_write, instr_done;

    logic        unused_instr;

    assign op       = Instr[6:0];
    assign funct3   = Instr[14:12];
    assign funct7b5 = Instr[30];

    assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

    // State register; synchronous reset returns to fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state output decode.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        AdrSrc     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        Illegal    = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        aluop      = 2'b00;

        unique case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_write  = MemReady;
                pc_write  = MemReady;
                if (MemReady) state_d = StDecode;
            end
            StDecode: begin
                // Precompute branch/jump target into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecR;
                    OpItype:         state_d = StExecI;
                    OpBranch:        state_d = (funct3[2:1] == 2'b00) ? StBranch : StTrap;
                    OpJal:           state_d = StJal;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (MemReady) state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc  = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                AdrSrc     = 1'b1;
                instr_done = MemReady;
                if (MemReady) state_d = StFetch;
            end
            StExecR: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b10;
                state_d = StAluWb;
            end
            StExecI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                ALUSrcA    = 2'b10;
                aluop      = 2'b01;
                instr_done = 1'b1;
                // funct3[0] selects bne (taken on not-equal) over beq.
                pc_write   = funct3[0] ? ~EQ : EQ;
                state_d    = StFetch;
            end
            StJal: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pc_write = 1'b1;
                state_d  = StAluWb;
            end
            StTrap: begin
                Illegal = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // ALU operation from the per-state ALUop and the instruction function bits.
    always_comb begin
        ALUctrl = 3'b000;
        case (aluop)
            2'b01: ALUctrl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b010:  ALUctrl = 3'b101;
                    3'b110:  ALUctrl = 3'b011;
                    3'b111:  ALUctrl = 3'b010;
                    3'b000:  ALUctrl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    default: ALUctrl = 3'b000;
                endcase
            end
            default: ALUctrl = 3'b000;
        endcase
    end

    // Immediate format depends only on the opcode.
    always_comb begin
        case (op)
            OpStore:  ImmSrc = 2'b01;
            OpBranch: ImmSrc = 2'b10;
            OpJal:    ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    // Reset suppresses every commit so an interrupted instruction never writes.
    assign MemReq    = mem_req & ~rst;
    assign MemWrite  = mem_write & ~rst;
    assign IRWrite   = ir_write & ~rst;
    assign PCWrite   = pc_write & ~rst;
    assign RegWrite  = reg_write & ~rst;
    assign InstrDone = instr_done & ~rst;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RV32I-subset core: a Moore-style FSM that steps each instruction through fetch, decode, execute, memory and writeback over a single shared ALU and unified memory port. It sits beside the datapath, reads the latched instruction register and the ALU `EQ` flag, and drives every mux select, write enable, ALU operation and memory handshake. Supported instructions: lw, sw, R-type (add/sub/and/or/slt), addi-class I-type, beq, bne and jal.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Instr` in 32: instruction register contents. Fields used: Op=[6:0], funct3=[14:12], funct7b5=[30].
- `EQ` in 1: ALU zero flag; 1 when SrcA == SrcB.
- `MemReady` in 1: memory completes the current request this cycle.
- `MemReq` out 1: memory access requested.
- `MemWrite` out 1: request is a store.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: load Instr and OldPC.
- `PCWrite` out 1: load PC from Result.
- `RegWrite` out 1: register file write.
- `ALUSrcA` out 2: 00 = PC, 01 = OldPC, 10 = rs1 register A.
- `ALUSrcB` out 2: 00 = rs2 register B, 01 = ImmExt, 10 = constant 4.
- `ResultSrc` out 2: 00 = ALUOut, 01 = memory Data register, 10 = live ALUResult.
- `ImmSrc` out 2: 00 = I-type, 01 = S-type, 10 = B-type, 11 = J-type.
- `ALUctrl` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `InstrDone` out 1: pulses high in the final cycle of each instruction.
- `Illegal` out 1: high while the FSM is in TRAP.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- Outputs decode from the state only, plus the `MemReady` and `EQ` gating listed below. Every output not listed for a state is 0.
- `ImmSrc` is a pure function of Op, valid in every state:
  - lw, I-type → 00
  - sw → 01
  - beq, bne → 10
  - jal → 11
  - any other Op → 00
- ALU operation, set per state:
  - ALUop 00 → add.
  - ALUop 01 → sub.
  - ALUop 10 → decode funct3: 010 → slt, 110 → or, 111 → and, 000 → sub if (funct7b5 & Op[5]) else add.
  - Any other funct3 → add. No latches.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite=PCWrite=MemReady. Hold in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jump target into ALUOut). Next state by Op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 with funct3 000 or 001 → BRANCH
  - 1101111 → JAL
  - anything else → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next state is MEMREAD if Op[5]=0, else MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1. Hold in MEMREAD until MemReady=1, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1. Next state FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1. Hold in MEMWRITE until MemReady=1; InstrDone=MemReady. Then go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUop 10. Next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUop 10. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1. Next state FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, InstrDone=1. PCWrite=EQ for funct3 000 and ~EQ for funct3 001. Next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next state ALUWB, which writes PC+4 to rd.
- TRAP: Illegal=1, no enables asserted. The FSM stays in TRAP until reset.

## Timing
- On a rising edge with rst=1, state becomes FETCH.
- While rst=1, PCWrite, IRWrite, RegWrite, MemWrite, MemReq and InstrDone are forced to 0 regardless of state. A reset mid-instruction therefore never commits a write.
- After reset release, outputs are the FETCH values:
  - MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUctrl=000, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - All other outputs 0.
- Cycles per instruction with MemReady held at 1:
  - lw 5
  - sw 4
  - R-type 4
  - I-type 4
  - beq/bne 3
  - jal 4
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. All other outputs stay stable during that wait.
- Memory handshake: MemReq, MemWrite and AdrSrc stay constant from the first request cycle until the cycle in which MemReady=1. A MemReady seen in any state without a request is ignored.
- InstrDone is high for exactly one cycle per retired instruction and never in TRAP.

## Test plan
- Reset, then add x3,x1,x2 (0x002081B3) with MemReady=1 → states FETCH, DECODE, EXECR, ALUWB. ALUctrl=000 in EXECR; RegWrite=1 and InstrDone=1 only in cycle 4.
- sub (0x402081B3) → ALUctrl=001 in EXECR. addi with bit30 set (0x40008093) → ALUctrl=000. slt, or, and → 101, 011, 010.
- lw (0x0000A183) with MemReady low for 3 cycles in MEMREAD → MemReq and AdrSrc=1 held 3 extra cycles, then MEMWB with ResultSrc=01, RegWrite=1. Total 8 cycles.
- beq (funct3 000) with EQ=1 → PCWrite=1 in BRANCH. With EQ=0 → PCWrite=0. bne (funct3 001) gives the inverse. 3 cycles each.
- jal (0x008000EF) → PCWrite=1 in JAL with ALUSrcA=01, ALUSrcB=10. ALUWB then has RegWrite=1. ImmSrc=11 throughout.
- Opcode 0x7F → TRAP; Illegal=1 and no enables for 10 cycles. Separately, assert rst during MEMWRITE with MemReady=1 → MemWrite=0 that cycle, and FETCH on the next cycle.
